apb_reg_slave: RTL and testbench

APB3 completer holding a small bank of 32-bit registers with programmable wait states and error response. It sits directly downstream of the APB master on the shared `apb_interface`. It services the master's write and read tasks and gives the testbench a deterministic target for protocol and error checks.

---
 rtl/apb_reg_slave_if.sv | 23 ++
 rtl/apb_reg_slave.sv | 130 +++++++++++++
 tb/tb_apb_reg_slave.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_reg_slave_if.sv
// APB3 bus bundle between one requester and the register-bank completer.
// Latency: none, wires only.
// Backpressure: the completer stretches transfers by holding PREADY low.
interface apb_reg_slave_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_slave.sv
// APB3 completer: ID register, saturating error counter, and a bank of R/W registers.
// Latency: PREADY rises WAIT_STATES+1 edges after the setup edge; a transfer is 3+WAIT_STATES cycles.
// Backpressure: inserts WAIT_STATES access cycles; a dropped PSEL aborts and a fresh setup restarts.
module apb_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA0B1_0001
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_reg_slave_if.slave  apb
);

    localparam int          IW         = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * NUM_REGS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_write;
    logic [3:0]    wait_cnt;
    logic [31:0]   err_cnt;
    logic [31:0]   regs [NUM_REGS];

    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;

    logic          setup_seen;
    logic [IW-1:0] idx;
    logic          acc_err;
    logic [31:0]   rd_val;

    assign apb.PRDATA  = prdata;
    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pslverr;

    assign setup_seen = apb.PSEL & ~apb.PENABLE;

    // Decode the latched request: word index, error classification, read mux.
    always_comb begin
        idx     = lat_addr[IW+1:2];
        acc_err = (lat_addr[1:0] != 2'b00)
                | (lat_addr >= ADDR_LIMIT)
                | (lat_write & ((idx == '0) | (idx == IW'(1))));
        if (idx == '0) begin
            rd_val = ID_VALUE;
        end else if (idx == IW'(1)) begin
            rd_val = err_cnt;
        end else begin
            rd_val = regs[idx];
        end
    end

    // Transfer FSM with registered PREADY/PRDATA/PSLVERR and the register bank.
    // A sampled setup is taken from any state, which covers both the normal
    // IDLE entry, the back-to-back DONE entry and a restart inside ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= '0;
            err_cnt   <= '0;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pready <= 1'b0;
            if (setup_seen) begin
                lat_addr  <= apb.PADDR;
                lat_wdata <= apb.PWDATA;
                lat_write <= apb.PWRITE;
                wait_cnt  <= 4'(WAIT_STATES);
                pslverr   <= 1'b0;
                state     <= ACCESS;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    ACCESS: begin
                        if (!apb.PSEL) begin
                            // Requester walked away: drop the transfer silently.
                            state <= IDLE;
                        end else if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else begin
                            pready <= 1'b1;
                            state  <= DONE;
                            if (acc_err) begin
                                pslverr <= 1'b1;
                                if (!lat_write) begin
                                    prdata <= '0;
                                end
                                if (err_cnt != 32'hFFFF_FFFF) begin
                                    err_cnt <= err_cnt + 32'd1;
                                end
                            end else begin
                                pslverr <= 1'b0;
                                if (lat_write) begin
                                    regs[idx] <= lat_wdata;
                                end else begin
                                    prdata <= rd_val;
                                end
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Testbench for apb_reg_slave (NUM_REGS=16, WAIT_STATES=1): directed scenarios plus
// randomized traffic scored against an address-map model of the register bank.
module tb_apb_reg_slave;

    localparam logic [31:0] ID = 32'hA0B1_0001;

    logic PCLK;
    logic PRESET;
    apb_reg_slave_if apb ();

    apb_reg_slave #(
        .NUM_REGS    (16),
        .WAIT_STATES (1),
        .ID_VALUE    (ID)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (apb)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents, error count, last read data seen on PRDATA.
    logic [31:0] mem [16];
    logic [31:0] m_errcnt;
    logic [31:0] m_rdata;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        m_errcnt = '0;
        m_rdata  = '0;
    endfunction

    function automatic void model_access(input bit wr, input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         output logic [31:0] exp_rd, output bit exp_err);
        int unsigned word;
        word    = addr / 4;
        exp_err = (addr % 4 != 0) || (addr >= 64) || (wr && addr < 8);
        if (exp_err) begin
            if (!wr) m_rdata = '0;
            if (m_errcnt != 32'hFFFF_FFFF) m_errcnt = m_errcnt + 1;
        end else if (wr) begin
            mem[word] = wdata;
        end else begin
            if (word == 0)      m_rdata = ID;
            else if (word == 1) m_rdata = m_errcnt;
            else                m_rdata = mem[word];
        end
        exp_rd = m_rdata;
    endfunction

    // One APB transfer, starting at a falling edge. With b2b set the bus is left in
    // the access phase so the next call's setup is sampled on the edge after PREADY.
    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit b2b,
                            output logic [31:0] rdata, output logic slverr, output int edges,
                            output logic pready_pre, output logic pready_post,
                            output logic slverr_hold);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr;
        apb.PWDATA  = wdata;
        @(negedge PCLK);
        pready_pre  = apb.PREADY;
        apb.PENABLE = 1'b1;
        edges = 0;
        while (1) begin
            @(negedge PCLK);
            edges++;
            if (apb.PREADY === 1'b1) break;
            if (edges >= 20) break;
        end
        rdata  = apb.PRDATA;
        slverr = apb.PSLVERR;
        if (edges >= 20) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout addr=%h got no PREADY in %0d edges", addr, edges);
        end
        pready_post = 1'b0;
        slverr_hold = slverr;
        if (!b2b) begin
            @(negedge PCLK);
            pready_post = apb.PREADY;
            slverr_hold = apb.PSLVERR;
            apb.PSEL    = 1'b0;
            apb.PENABLE = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic se, pp, po, sh; int ed;
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        model_reset();
        @(negedge PCLK);
        checks++; if (apb.PREADY !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", apb.PREADY); end
        checks++; if (apb.PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", apb.PSLVERR); end
        checks++; if (apb.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", apb.PRDATA); end
        apb_xfer(1'b0, 32'h00, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== ID) begin failures++; $display("FAIL reset_id got=%h exp=%h", rd, ID); end
        apb_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_errcnt got=%h exp=0", rd); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd, prev; logic se, pp, po, sh; int ed; bit ee;
        prev = apb.PRDATA;
        model_access(1'b1, 32'h08, 32'hDEADBEEF, erd, ee);
        apb_xfer(1'b1, 32'h08, 32'hDEADBEEF, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (ed !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", ed); end
        checks++; if (rd !== prev) begin failures++; $display("FAIL wr_prdata_hold got=%h exp=%h", rd, prev); end
        checks++; if (po !== 1'b0) begin failures++; $display("FAIL wr_pready_one_cycle got=%b exp=0", po); end
        model_access(1'b0, 32'h08, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h08, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (se !== 1'b0) begin failures++; $display("FAIL rd_slverr got=%b exp=0", se); end
        checks++; if (ed !== 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", ed); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic se, pp, po, sh; int ed; bit ee;
        model_access(1'b1, 32'h00, 32'd5, erd, ee);
        apb_xfer(1'b1, 32'h00, 32'd5, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (se !== 1'b1) begin failures++; $display("FAIL err_wr_reg0 slverr got=%b exp=1", se); end
        checks++; if (sh !== 1'b1) begin failures++; $display("FAIL err_slverr_hold got=%b exp=1", sh); end
        model_access(1'b0, 32'h06, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h06, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (se !== 1'b1) begin failures++; $display("FAIL err_misalign slverr got=%b exp=1", se); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_misalign prdata got=%h exp=0", rd); end
        model_access(1'b0, 32'h40, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h40, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (se !== 1'b1) begin failures++; $display("FAIL err_range slverr got=%b exp=1", se); end
        model_access(1'b0, 32'h04, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== 32'd3) begin failures++; $display("FAIL err_count got=%0d exp=3", rd); end
        checks++; if (se !== 1'b0) begin failures++; $display("FAIL err_count slverr got=%b exp=0", se); end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic se, pp, po, sh; int ed; bit ee;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 32'h0C; apb.PWDATA = 32'd7;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            checks++; if (apb.PREADY !== 1'b0) begin failures++; $display("FAIL abort_pready cyc=%0d got=%b exp=0", i, apb.PREADY); end
        end
        model_access(1'b0, 32'h0C, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h0C, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== erd) begin failures++; $display("FAIL abort_readback got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd; logic se, pp, po, sh; int ed; bit ee;
        apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
        apb.PADDR = 32'h10; apb.PWDATA = 32'd9;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        checks++; if (apb.PREADY !== 1'b0) begin failures++; $display("FAIL midrst_pready got=%b exp=0", apb.PREADY); end
        checks++; if (apb.PRDATA !== 32'h0) begin failures++; $display("FAIL midrst_prdata got=%h exp=0", apb.PRDATA); end
        PRESET = 1'b0;
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        model_reset();
        @(negedge PCLK);
        model_access(1'b0, 32'h10, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h10, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL midrst_readback got=%h exp=0", rd); end
        model_access(1'b0, 32'h04, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== erd) begin failures++; $display("FAIL midrst_errcnt got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic se, pp, po, sh; int ed; bit ee;
        model_access(1'b1, 32'h14, 32'd1, erd, ee);
        apb_xfer(1'b1, 32'h14, 32'd1, 1'b1, rd, se, ed, pp, po, sh);
        checks++; if (ed !== 2) begin failures++; $display("FAIL b2b_wr_latency got=%0d exp=2", ed); end
        model_access(1'b0, 32'h14, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h14, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (pp !== 1'b0) begin failures++; $display("FAIL b2b_pready_one_cycle got=%b exp=0", pp); end
        checks++; if (ed !== 2) begin failures++; $display("FAIL b2b_rd_latency got=%0d exp=2", ed); end
        checks++; if (rd !== 32'd1) begin failures++; $display("FAIL b2b_readback got=%h exp=1", rd); end
        checks++; if (po !== 1'b0) begin failures++; $display("FAIL b2b_pready_post got=%b exp=0", po); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wdata; logic se, pp, po, sh; int ed; bit ee, wr, b2b;
        int unsigned sel;
        for (int n = 0; n < 60; n++) begin
            sel   = $urandom_range(0, 9);
            if (sel < 7)       addr = 32'($urandom_range(0, 15)) * 4;
            else if (sel == 7) addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) addr = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            else               addr = ($urandom() | 32'h8000_0000) & 32'hFFFF_FFFC;
            wr    = 1'($urandom_range(0, 1));
            b2b   = 1'($urandom_range(0, 1));
            wdata = $urandom();
            model_access(wr, addr, wdata, erd, ee);
            apb_xfer(wr, addr, wdata, b2b, rd, se, ed, pp, po, sh);
            checks++; if (rd !== erd) begin failures++; $display("FAIL rnd_prdata n=%0d addr=%h wr=%0d got=%h exp=%h", n, addr, wr, rd, erd); end
            checks++; if (se !== ee) begin failures++; $display("FAIL rnd_slverr n=%0d addr=%h wr=%0d got=%b exp=%b", n, addr, wr, se, ee); end
            checks++; if (ed !== 2) begin failures++; $display("FAIL rnd_latency n=%0d got=%0d exp=2", n, ed); end
            checks++; if (pp !== 1'b0) begin failures++; $display("FAIL rnd_pready_pre n=%0d got=%b exp=0", n, pp); end
            if (!b2b) begin
                checks++; if (sh !== ee) begin failures++; $display("FAIL rnd_slverr_hold n=%0d got=%b exp=%b", n, sh, ee); end
            end
        end
        // Drain any back-to-back leftover so the bus ends idle.
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        // Final sweep of the R/W bank against the model.
        for (int w = 2; w < 16; w++) begin
            model_access(1'b0, 32'(w * 4), 32'h0, erd, ee);
            apb_xfer(1'b0, 32'(w * 4), 32'h0, 1'b0, rd, se, ed, pp, po, sh);
            checks++; if (rd !== erd) begin failures++; $display("FAIL sweep reg=%0d got=%h exp=%h", w, rd, erd); end
        end
        model_access(1'b0, 32'h04, 32'h0, erd, ee);
        apb_xfer(1'b0, 32'h04, 32'h0, 1'b0, rd, se, ed, pp, po, sh);
        checks++; if (rd !== erd) begin failures++; $display("FAIL sweep_errcnt got=%h exp=%h", rd, erd); end
    endtask

    initial begin
        PRESET      = 1'b1;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        model_reset();
        @(negedge PCLK);
        test_reset();
        test_write_read();
        test_errors();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
